// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// instruction_fetch_unit : PC generation, 1-cycle imem fetch, prefetch queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            load_mode,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instruction
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   pc_mem_q  [FIFO_DEPTH];
  logic [31:0]       ins_mem_q [FIFO_DEPTH];

  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  occupancy;

  // Credit counts the in-flight word so a response always finds a free slot.
  assign occupancy = count_q + CNT_W'(inflight_q);
  assign issue     = (state_q == ST_FETCH) && !redirect_valid
                     && (occupancy < CNT_W'(FIFO_DEPTH));
  assign push      = inflight_q && !redirect_valid;
  assign pop       = (count_q != '0) && out_ready && !redirect_valid;

  assign imem_req        = issue;
  assign imem_addr       = fetch_pc_q;
  assign out_valid       = (count_q != '0);
  assign out_pc          = pc_mem_q[rd_ptr_q];
  assign out_instruction = ins_mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE:  state_d = load_mode ? ST_LOAD : ST_FETCH;
      ST_FETCH: if (load_mode)  state_d = ST_LOAD;
      ST_LOAD:  if (!load_mode) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        req_pc_d   = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_VECTOR;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]  <= req_pc_q;
      ins_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

`default_nettype wire
